ltssm_polling_ctrl: RTL and testbench

Sequencer for the LTSSM Polling state. It starts when the top-level link controller enters POLLING and drives the ordered-set transmitter through Polling.Active (TS1), Polling.Configuration (TS2) and Polling.Compliance (compliance pattern). It tracks per-lane receive matches and the spec timeouts, then reports success (go to Configuration) or failure (go back to Detect) to the top-level controller.

---
 rtl/ltssm_polling_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_ltssm_polling_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ltssm_polling_ctrl.sv
// rtl/ltssm_polling_ctrl.sv - LTSSM Polling substate sequencer (Active, Configuration, Compliance)
module ltssm_polling_ctrl #(
    parameter int NUM_LANES          = 1,
    parameter int TS_TX_MIN          = 1024,
    parameter int RX_MATCH           = 8,
    parameter int TS2_TX_MIN         = 16,
    parameter int ACTIVE_TIMEOUT_CYC = 6000000,
    parameter int CFG_TIMEOUT_CYC    = 12000000
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [NUM_LANES-1:0] lane_detected_i,
    input  logic                 exit_compliance_i,
    output logic                 os_tx_valid_o,
    output logic [1:0]           os_tx_type_o,
    input  logic                 os_tx_ready_i,
    output logic [NUM_LANES-1:0] lane_en_o,
    input  logic [NUM_LANES-1:0] rx_os_valid_i,
    input  logic [NUM_LANES-1:0] rx_os_is_ts2_i,
    input  logic [NUM_LANES-1:0] rx_os_pad_i,
    input  logic [NUM_LANES-1:0] rx_os_compliance_i,
    output logic [1:0]           state_o,
    output logic                 done_o,
    output logic                 to_detect_o
);

    localparam int TW  = $clog2(CFG_TIMEOUT_CYC + 1);
    localparam int TXW = $clog2(TS_TX_MIN + 1);
    localparam int MW  = $clog2(RX_MATCH + 1);
    localparam int T2W = $clog2(TS2_TX_MIN + 1);

    localparam logic [TW-1:0]  ACT_LAST  = TW'(ACTIVE_TIMEOUT_CYC - 1);
    localparam logic [TW-1:0]  CFG_LAST  = TW'(CFG_TIMEOUT_CYC - 1);
    localparam logic [TXW-1:0] TX_MAX    = TXW'(TS_TX_MIN);
    localparam logic [MW-1:0]  MATCH_MAX = MW'(RX_MATCH);
    localparam logic [T2W-1:0] TS2_MAX   = T2W'(TS2_TX_MIN);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_ACTIVE     = 2'd1,
        ST_CONFIG     = 2'd2,
        ST_COMPLIANCE = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_LANES-1:0]   lane_en_q, lane_en_d;
    logic [TW-1:0]          timer_q;
    logic [TXW-1:0]         tx_cnt_q, tx_cnt_d;
    logic [T2W-1:0]         ts2_tx_cnt_q, ts2_tx_cnt_d;
    logic                   ts2_seen_q, ts2_seen_d;
    logic [MW-1:0]          match_q [NUM_LANES];
    logic [MW-1:0]          match_d [NUM_LANES];
    logic [MW-1:0]          comp_q  [NUM_LANES];
    logic [MW-1:0]          comp_d  [NUM_LANES];
    logic                   done_q, done_d;
    logic                   to_detect_q, to_detect_d;
    logic                   handshake;
    logic                   entry_clear;
    logic [NUM_LANES-1:0]   lane_ok;
    logic [NUM_LANES-1:0]   lane_comp;

    assign os_tx_valid_o = (state_q != ST_IDLE);
    assign state_o       = state_q;
    assign lane_en_o     = lane_en_q;
    assign done_o        = done_q;
    assign to_detect_o   = to_detect_q;
    assign handshake     = os_tx_valid_o & os_tx_ready_i;

    always_comb begin
        os_tx_type_o = 2'd0;
        case (state_q)
            ST_CONFIG:     os_tx_type_o = 2'd1;
            ST_COMPLIANCE: os_tx_type_o = 2'd2;
            default:       os_tx_type_o = 2'd0;
        endcase
    end

    // Counters are evaluated with this cycle's events folded in so that the
    // completing handshake/strobe moves the state on the very next edge.
    always_comb begin
        tx_cnt_d     = tx_cnt_q;
        ts2_seen_d   = ts2_seen_q;
        ts2_tx_cnt_d = ts2_tx_cnt_q;
        lane_ok      = '0;
        lane_comp    = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            match_d[i] = match_q[i];
            comp_d[i]  = comp_q[i];
            if (lane_en_q[i] && rx_os_valid_i[i]) begin
                if (state_q == ST_ACTIVE) begin
                    if (rx_os_pad_i[i] && !rx_os_compliance_i[i]) begin
                        if (match_q[i] != MATCH_MAX) match_d[i] = match_q[i] + MW'(1);
                    end else if (rx_os_pad_i[i] && !rx_os_is_ts2_i[i]) begin
                        if (comp_q[i] != MATCH_MAX) comp_d[i] = comp_q[i] + MW'(1);
                    end else begin
                        match_d[i] = '0;
                        comp_d[i]  = '0;
                    end
                end else if (state_q == ST_CONFIG) begin
                    if (rx_os_pad_i[i] && rx_os_is_ts2_i[i]) begin
                        if (match_q[i] != MATCH_MAX) match_d[i] = match_q[i] + MW'(1);
                        ts2_seen_d = 1'b1;
                    end else begin
                        match_d[i] = '0;
                    end
                end
            end
            lane_ok[i]   = !lane_en_q[i] || (match_d[i] == MATCH_MAX);
            lane_comp[i] = lane_en_q[i] && (comp_d[i] == MATCH_MAX);
        end
        if (state_q == ST_ACTIVE && handshake && tx_cnt_q != TX_MAX)
            tx_cnt_d = tx_cnt_q + TXW'(1);
        if (state_q == ST_CONFIG && handshake && ts2_seen_d && ts2_tx_cnt_q != TS2_MAX)
            ts2_tx_cnt_d = ts2_tx_cnt_q + T2W'(1);
    end

    always_comb begin
        state_d     = state_q;
        lane_en_d   = lane_en_q;
        done_d      = 1'b0;
        to_detect_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (|lane_detected_i) begin
                        lane_en_d = lane_detected_i;
                        state_d   = ST_ACTIVE;
                    end else begin
                        to_detect_d = 1'b1;
                    end
                end
            end
            ST_ACTIVE: begin
                if (|lane_comp) begin
                    state_d = ST_COMPLIANCE;
                end else if (tx_cnt_d == TX_MAX && &lane_ok) begin
                    state_d = ST_CONFIG;
                end else if (timer_q == ACT_LAST) begin
                    state_d     = ST_IDLE;
                    to_detect_d = 1'b1;
                end
            end
            ST_CONFIG: begin
                if (&lane_ok && ts2_tx_cnt_d == TS2_MAX) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (timer_q == CFG_LAST) begin
                    state_d     = ST_IDLE;
                    to_detect_d = 1'b1;
                end
            end
            default: begin
                if (exit_compliance_i) state_d = ST_ACTIVE;
            end
        endcase
        if (abort_i) begin
            state_d     = ST_IDLE;
            lane_en_d   = lane_en_q;
            done_d      = 1'b0;
            to_detect_d = 1'b0;
        end
    end

    assign entry_clear = (state_d != state_q) || abort_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            lane_en_q    <= '0;
            timer_q      <= '0;
            tx_cnt_q     <= '0;
            ts2_tx_cnt_q <= '0;
            ts2_seen_q   <= 1'b0;
            done_q       <= 1'b0;
            to_detect_q  <= 1'b0;
            for (int i = 0; i < NUM_LANES; i++) begin
                match_q[i] <= '0;
                comp_q[i]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            lane_en_q   <= lane_en_d;
            done_q      <= done_d;
            to_detect_q <= to_detect_d;
            if (entry_clear) begin
                timer_q      <= '0;
                tx_cnt_q     <= '0;
                ts2_tx_cnt_q <= '0;
                ts2_seen_q   <= 1'b0;
                for (int i = 0; i < NUM_LANES; i++) begin
                    match_q[i] <= '0;
                    comp_q[i]  <= '0;
                end
            end else begin
                if (state_q != ST_IDLE && state_q != ST_COMPLIANCE) timer_q <= timer_q + TW'(1);
                tx_cnt_q     <= tx_cnt_d;
                ts2_tx_cnt_q <= ts2_tx_cnt_d;
                ts2_seen_q   <= ts2_seen_d;
                for (int i = 0; i < NUM_LANES; i++) begin
                    match_q[i] <= match_d[i];
                    comp_q[i]  <= comp_d[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_ltssm_polling_ctrl.sv
// tb/tb_ltssm_polling_ctrl.sv - directed self-checking bench for ltssm_polling_ctrl
module tb_ltssm_polling_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, abort, exit_comp, ready;
    logic [1:0] lanes_det;
    logic       tx_valid;
    logic [1:0] tx_type;
    logic [1:0] lane_en;
    logic [1:0] rx_valid, rx_ts2, rx_pad, rx_comp;
    logic [1:0] state;
    logic       done, to_detect;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ltssm_polling_ctrl #(
        .NUM_LANES(2), .TS_TX_MIN(16), .RX_MATCH(8), .TS2_TX_MIN(4),
        .ACTIVE_TIMEOUT_CYC(200), .CFG_TIMEOUT_CYC(400)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
        .lane_detected_i(lanes_det), .exit_compliance_i(exit_comp),
        .os_tx_valid_o(tx_valid), .os_tx_type_o(tx_type), .os_tx_ready_i(ready),
        .lane_en_o(lane_en), .rx_os_valid_i(rx_valid), .rx_os_is_ts2_i(rx_ts2),
        .rx_os_pad_i(rx_pad), .rx_os_compliance_i(rx_comp), .state_o(state),
        .done_o(done), .to_detect_o(to_detect)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rx(input logic [1:0] v, input logic [1:0] t2, input logic [1:0] p, input logic [1:0] c);
        rx_valid = v; rx_ts2 = t2; rx_pad = p; rx_comp = c;
    endtask

    task automatic do_start(input logic [1:0] l);
        start = 1'b1; lanes_det = l;
        tick();
        start = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    // 16 TS1 handshakes with 8 pad TS1 on both lanes: CONFIG on the 16th
    task automatic active_to_config(input string tag);
        for (int k = 1; k <= 16; k++) begin
            if (k <= 8) set_rx(2'b11, 2'b00, 2'b11, 2'b00);
            else        set_rx(2'b00, 2'b00, 2'b00, 2'b00);
            tick();
            if (k == 15) check({tag, "_still_active"}, state, 1);
        end
        check({tag, "_config"}, state, 2);
        check({tag, "_type_ts2"}, tx_type, 1);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; exit_comp = 1'b0; ready = 1'b0;
        lanes_det = 2'b00;
        set_rx(2'b00, 2'b00, 2'b00, 2'b00);
        tick(); tick();
        check("rst_state", state, 0);
        check("rst_valid", tx_valid, 0);
        check("rst_type", tx_type, 0);
        check("rst_lane_en", lane_en, 0);
        check("rst_pulses", {done, to_detect}, 0);
        rst_n = 1'b1;
        tick();

        // happy path
        ready = 1'b1;
        do_start(2'b11);
        check("hp_active", state, 1);
        check("hp_lane_en", lane_en, 2'b11);
        check("hp_valid", tx_valid, 1);
        check("hp_type_ts1", tx_type, 0);
        active_to_config("hp");
        for (int k = 1; k <= 8; k++) begin
            set_rx(2'b11, 2'b11, 2'b11, 2'b00);
            tick();
            if (k == 7) check("hp_cfg_wait", {state, done}, {2'd2, 1'b0});
        end
        set_rx(2'b00, 2'b00, 2'b00, 2'b00);
        check("hp_done", {state, done, to_detect}, {2'd0, 1'b1, 1'b0});
        check("hp_idle_valid", tx_valid, 0);
        tick();
        check("hp_done_once", done, 0);

        // broken run on lane 1
        do_start(2'b11);
        for (int k = 1; k <= 20; k++) begin
            logic [1:0] v, p;
            v = 2'b01; p = 2'b01;
            if (k <= 15) v[1] = 1'b1;
            if (k <= 15 && k != 8) p[1] = 1'b1;
            set_rx(v, 2'b00, p, 2'b00);
            tick();
        end
        check("br_no_exit", state, 1);
        set_rx(2'b11, 2'b00, 2'b11, 2'b00);
        tick();
        set_rx(2'b00, 2'b00, 2'b00, 2'b00);
        check("br_config", state, 2);
        do_abort();
        check("abort_idle", {state, tx_valid, done, to_detect}, {2'd0, 1'b0, 1'b0, 1'b0});

        // active timeout with no handshakes
        ready = 1'b0;
        do_start(2'b11);
        for (int k = 1; k <= 199; k++) tick();
        check("to_before", {state, to_detect}, {2'd1, 1'b0});
        tick();
        check("to_fire", {state, to_detect}, {2'd0, 1'b1});
        tick();
        check("to_once", to_detect, 0);

        // compliance entry and exit
        ready = 1'b1;
        do_start(2'b11);
        for (int k = 1; k <= 8; k++) begin
            set_rx(2'b01, 2'b00, 2'b01, 2'b01);
            tick();
            if (k == 7) check("cp_wait", state, 1);
        end
        set_rx(2'b00, 2'b00, 2'b00, 2'b00);
        check("cp_state", state, 3);
        check("cp_type", {tx_valid, tx_type}, {1'b1, 2'd2});
        tick(); tick();
        check("cp_hold", state, 3);
        exit_comp = 1'b1;
        tick();
        exit_comp = 1'b0;
        check("cp_exit", {state, tx_type}, {2'd1, 2'd0});
        active_to_config("cp_cleared");
        do_abort();

        // no lanes detected
        do_start(2'b00);
        check("nolane", {state, to_detect}, {2'd0, 1'b1});
        tick();
        check("nolane_once", to_detect, 0);

        // abort together with start
        abort = 1'b1;
        do_start(2'b11);
        abort = 1'b0;
        check("abort_start", {state, tx_valid, to_detect}, {2'd0, 1'b0, 1'b0});

        // success and config timeout in the same cycle
        do_start(2'b11);
        active_to_config("st");
        for (int k = 1; k <= 400; k++) begin
            if (k >= 393) set_rx(2'b11, 2'b11, 2'b11, 2'b00);
            else          set_rx(2'b00, 2'b00, 2'b00, 2'b00);
            tick();
            if (k == 399) check("st_wait", state, 2);
        end
        set_rx(2'b00, 2'b00, 2'b00, 2'b00);
        check("st_done_only", {state, done, to_detect}, {2'd0, 1'b1, 1'b0});

        // asynchronous reset in CONFIG
        do_start(2'b11);
        active_to_config("ar");
        tick(); tick();
        rst_n = 1'b0;
        #2;
        check("ar_async", {state, tx_valid, lane_en}, {2'd0, 1'b0, 2'b00});
        #1;
        rst_n = 1'b1;
        tick();
        check("ar_after", {state, done, to_detect}, {2'd0, 1'b0, 1'b0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
